// File: rtl/dmem_loader_if.sv
// Loader bundle: load control, byte-stream valid/ready handshake and data-memory write port.
interface dmem_loader_if #(
    parameter int WORD     = 16,
    parameter int ADDRESSL = 10
);
    logic                start;
    logic                abort;
    logic [ADDRESSL-1:0] base_addr;
    logic [ADDRESSL:0]   word_count;
    logic [7:0]          in_byte;
    logic                in_valid;
    logic                in_ready;
    logic [ADDRESSL-1:0] mem_addr;
    logic [WORD-1:0]     mem_wdata;
    logic                mem_write;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, base_addr, word_count, in_byte, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_write, busy, done
    );

    modport slave (
        input  start, abort, base_addr, word_count, in_byte, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_write, busy, done
    );
endinterface

// File: rtl/dmem_loader.sv
// Byte-stream to big-endian 16-bit word loader writing consecutive data-memory addresses.
// Latency: 3 cycles per word minimum (HIGH, LOW, WRITE); in_valid low stalls HIGH/LOW indefinitely.
module dmem_loader #(
    parameter int WORD     = 16,
    parameter int LENGTH   = 1024,
    parameter int ADDRESSL = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    dmem_loader_if.slave s_if
);
    typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_WRITE, S_DONE} state_t;

    localparam logic [ADDRESSL:0]   LEN_C  = (ADDRESSL+1)'(LENGTH);
    localparam logic [ADDRESSL-1:0] LAST_C = ADDRESSL'(LENGTH - 1);
    localparam logic [ADDRESSL:0]   ONE_C  = (ADDRESSL+1)'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDRESSL-1:0] r_addr;
    logic [ADDRESSL-1:0] r_mem_addr;
    logic [ADDRESSL:0]   r_remaining;
    logic [WORD-1:0]     r_wdata;
    logic                w_take;

    // A byte is kept only when it transfers and abort does not override it.
    assign w_take = s_if.in_valid && !s_if.abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (s_if.start) begin
                    w_next = (s_if.word_count == '0) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (s_if.abort)         w_next = S_IDLE;
                else if (s_if.in_valid) w_next = S_LOW;
            end
            S_LOW: begin
                if (s_if.abort)         w_next = S_IDLE;
                else if (s_if.in_valid) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (s_if.abort)              w_next = S_IDLE;
                else if (r_remaining == ONE_C) w_next = S_DONE;
                else                         w_next = S_HIGH;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_if.in_ready  = 1'b0;
        s_if.busy      = 1'b0;
        s_if.mem_write = 1'b0;
        s_if.done      = 1'b0;
        unique case (r_state)
            S_HIGH, S_LOW: begin
                s_if.in_ready = 1'b1;
                s_if.busy     = 1'b1;
            end
            S_WRITE: begin
                s_if.busy      = 1'b1;
                s_if.mem_write = 1'b1;
            end
            S_DONE:  s_if.done = 1'b1;
            default: ;
        endcase
    end

    // mem_addr is a separate copy so it holds the written address after r_addr advances.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (s_if.start && (s_if.word_count != '0)) begin
                        r_addr      <= s_if.base_addr;
                        r_remaining <= (s_if.word_count > LEN_C) ? LEN_C : s_if.word_count;
                    end
                end
                S_HIGH: begin
                    if (w_take) r_wdata[WORD-1 -: 8] <= s_if.in_byte;
                end
                S_LOW: begin
                    if (w_take) begin
                        r_wdata[7:0] <= s_if.in_byte;
                        r_mem_addr   <= r_addr;
                    end
                end
                S_WRITE: begin
                    r_addr      <= (r_addr == LAST_C) ? '0 : r_addr + 1'b1;
                    r_remaining <= r_remaining - ONE_C;
                end
                default: ;
            endcase
        end
    end

    assign s_if.mem_addr  = r_mem_addr;
    assign s_if.mem_wdata = r_wdata;
endmodule

// File: doc/dmem_loader.md
Name: dmem_loader

Overview:
Sequential loader directly upstream of the data memory: it accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It writes those words to consecutive data-memory addresses starting at a programmable base. The top level muxes the loader's address/data/write-enable onto the data memory while busy is high and holds the processor off meanwhile. It is used for test-image preload and host download.

Parameters:
WORD, 16, data-memory word width (fixed two bytes per word; only 16 supported)
LENGTH, 1024, number of data-memory words
ADDRESSL, 10, data-memory address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a load; sampled only in IDLE
abort  input  1  terminate load early; sampled in HIGH/LOW/WRITE
base_addr  input  ADDRESSL  first destination word address, latched on start
word_count  input  ADDRESSL+1  number of words to load, latched on start
in_byte  input  8  stream byte
in_valid  input  1  in_byte valid
in_ready  output  1  loader accepts byte this cycle
mem_addr  output  ADDRESSL  data-memory address
mem_wdata  output  WORD  data-memory write data
mem_write  output  1  data-memory write enable (one cycle per word)
busy  output  1  load in progress; top level gives memory port to loader
done  output  1  one-cycle pulse at normal completion

Behaviour:
- States: IDLE, HIGH, LOW, WRITE, DONE. All outputs are functions of registered state only.
- Reset (rst=1 at clk edge): state=IDLE; in_ready, mem_write, busy, done=0; mem_addr=0; mem_wdata=0; internal address, remaining count and partial byte are cleared. Reset mid-load discards any half-assembled word; no write is issued.
- IDLE: on start=1:
  - word_count=0: go to DONE (done pulses next cycle, no writes).
  - otherwise: latch addr=base_addr and remaining=min(word_count, LENGTH), then go to HIGH.
  - abort is ignored in IDLE.
- HIGH: in_ready=1, busy=1. A byte transfers when in_valid&in_ready at the edge; it is stored in mem_wdata[15:8] and the state goes to LOW.
- LOW: in_ready=1, busy=1. On transfer, the byte goes to mem_wdata[7:0] and the state goes to WRITE.
- WRITE: in_ready=0, busy=1, mem_write=1, mem_addr=addr, mem_wdata=assembled word. This lasts exactly one cycle. Next edge:
  - addr=(addr+1) mod LENGTH, wrapping 1023->0.
  - remaining decrements.
  - Go to DONE if remaining was 1, else to HIGH.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in DONE.
- Throughput: minimum 3 cycles per word with in_valid held high.
- in_valid low in HIGH/LOW stalls indefinitely; no timeout.
- abort=1 in HIGH or LOW: go to IDLE next edge. No write is issued, done is not asserted, and the partial word is discarded.
- abort=1 in WRITE: that cycle's write still completes (mem_write=1), then go to IDLE without done.
- abort and byte transfer in the same cycle: abort wins and the byte is consumed and dropped (in_ready was 1).
- start while busy: ignored; no relatch.
- mem_addr/mem_wdata hold their last values outside WRITE. Consumers qualify them with mem_write.

Test Plan:
- Basic load: rst, start with base_addr=10, word_count=3, stream 12 34 56 78 9A BC with in_valid held -> writes 0x1234@10, 0x5678@11, 0x9ABC@12. mem_write is high on cycles 3, 6, 9 after the HIGH entry, and done pulses once, the cycle after the last write.
- Wrap: base_addr=1023, word_count=2, bytes AA BB CC DD -> 0xAABB@1023, 0xCCDD@0. busy drops with done.
- Zero count and clamp: word_count=0 -> done one cycle after start, no mem_write. word_count=2047 -> remaining=1024, exactly 1024 writes.
- Stall and backpressure: insert 5-cycle in_valid gaps between bytes -> state holds, in_ready stays 1 in HIGH/LOW and 0 in WRITE, and written data is unchanged versus the gap-free run.
- Abort: abort in LOW after high byte 0x11 -> no write, no done, IDLE next cycle. Abort asserted in WRITE -> that write occurs, no done. A fresh start afterwards loads correctly.
- Reset mid-load: rst during LOW of word 2 -> all outputs 0 the next cycle, no further writes, and start afterwards begins at the new base.
